// File: rtl/apb_slave_mem.sv
// APB completer with a small word-addressed memory, byte strobes, programmable
// wait states and error responses for bad address, misalignment and unprivileged word-0 writes.
module apb_slave_mem #(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter int                       MEM_DEPTH     = 16,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = '0
) (
  input  logic                      pclk,
  input  logic                      preset,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [ADDRESS_WIDTH-1:0]  paddr,
  input  logic [DATA_WIDTH-1:0]     pwdata,
  input  logic [DATA_WIDTH/8-1:0]   pstrb,
  input  logic [2:0]                pprot,
  input  logic [3:0]                cfg_wait_states,
  output logic [DATA_WIDTH-1:0]     prdata,
  output logic                      pready,
  output logic                      pslverr
);

  localparam int BYTES     = DATA_WIDTH / 8;
  localparam int LANE_BITS = $clog2(BYTES);
  localparam int IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDRESS_WIDTH-1:0] SPAN      = ADDRESS_WIDTH'(MEM_DEPTH * BYTES);
  localparam logic [ADDRESS_WIDTH-1:0] LANE_MASK = ADDRESS_WIDTH'(BYTES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic                     write_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [BYTES-1:0]         strb_q;
  logic                     priv_q;
  logic [3:0]               wait_q;
  logic [3:0]               wait_cnt;
  logic [DATA_WIDTH-1:0]    mem [MEM_DEPTH];

  logic [ADDRESS_WIDTH-1:0] offset;
  logic [IDX_W-1:0]         word_idx;
  logic                     in_range, aligned, priv_err, xfer_err;
  logic [DATA_WIDTH-1:0]    rd_word;
  logic                     start, done_now, wr_en;

  // Only the privilege bit matters; the other protection bits are accepted and dropped.
  logic unused_prot;
  assign unused_prot = ^pprot[2:1];

  always_comb begin
    offset   = addr_q - BASE_ADDR;
    in_range = (addr_q >= BASE_ADDR) && (offset < SPAN);
    aligned  = (addr_q & LANE_MASK) == '0;
    word_idx = IDX_W'(offset >> LANE_BITS);
    priv_err = write_q && (offset == '0) && !priv_q;
    xfer_err = !in_range || !aligned || priv_err;
    rd_word  = in_range ? mem[word_idx] : '0;
  end

  // A new transfer can be latched from IDLE or straight out of a completing cycle.
  assign start    = psel && !penable &&
                    ((state == IDLE) || ((state == ACCESS) && pready));
  assign done_now = ((state == SETUP) && psel && penable && (wait_q == 4'd0)) ||
                    ((state == ACCESS) && psel && !pready && (wait_cnt <= 4'd1) &&
                     (wait_q != 4'd0));
  assign wr_en    = (state == ACCESS) && pready && psel && write_q && !pslverr;

  always_ff @(posedge pclk) begin
    if (preset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      pready   <= 1'b0;
      pslverr  <= 1'b0;
      prdata   <= '0;
      // NOTE: storage is reset word by word because a reset must read back as zero;
      // this keeps the array in flops rather than a RAM macro.
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments let the write below use the old latched
      // address/data even when a back-to-back transfer relatches them on this edge.
      if (wr_en) begin
        for (int b = 0; b < BYTES; b++)
          if (strb_q[b]) mem[word_idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end

      if (start) begin
        addr_q  <= paddr;
        write_q <= pwrite;
        wdata_q <= pwdata;
        strb_q  <= pstrb;
        priv_q  <= pprot[0];
        wait_q  <= cfg_wait_states;
      end

      case (state)
        IDLE:   if (start) state <= SETUP;
        SETUP:  begin
          if (psel && penable) begin
            state    <= ACCESS;
            wait_cnt <= wait_q;
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          if (!psel)       state <= IDLE;
          else if (pready) state <= start ? SETUP : IDLE;
          else if (wait_cnt > 4'd1) wait_cnt <= wait_cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase

      pready  <= done_now;
      pslverr <= done_now && xfer_err;
      prdata  <= (done_now && !write_q && !xfer_err) ? rd_word : '0;
    end
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Table-driven bench for apb_slave_mem: expected responses queued at setup,
// compared when pready rises, plus hand-written abort/reset/back-to-back sequences.
module tb_apb_slave_mem;

  logic        pclk = 1'b0;
  logic        preset, psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic [3:0]  pstrb, cfg_wait_states;
  logic [2:0]  pprot;
  logic        pready, pslverr;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [2:0]  prot;
    logic [3:0]  ws;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [3:0]  ws;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  apb_slave_mem dut (
    .pclk           (pclk),
    .preset         (preset),
    .psel           (psel),
    .penable        (penable),
    .pwrite         (pwrite),
    .paddr          (paddr),
    .pwdata         (pwdata),
    .pstrb          (pstrb),
    .pprot          (pprot),
    .cfg_wait_states(cfg_wait_states),
    .prdata         (prdata),
    .pready         (pready),
    .pslverr        (pslverr)
  );

  always #5 pclk = ~pclk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic setup_phase(input vec_t v);
    exp_t e;
    psel = 1'b1; penable = 1'b0; pwrite = v.wr; paddr = v.addr;
    pwdata = v.data; pstrb = v.strb; pprot = v.prot; cfg_wait_states = v.ws;
    e.exp_err = v.exp_err; e.exp_rdata = v.exp_rdata; e.ws = v.ws;
    sb.push_back(e);
  endtask

  // Setup-phase edge, then access phase until pready; returns with pready high.
  task automatic run_access(input string name, input bit scramble);
    exp_t e;
    int   cyc;
    @(posedge pclk); #1;
    check({name, " setup pready"}, {31'b0, pready}, 32'd0);
    penable = 1'b1;
    if (scramble) begin
      paddr = paddr ^ 32'h8; pwdata = ~pwdata; pstrb = ~pstrb;
      pprot = ~pprot; pwrite = ~pwrite; cfg_wait_states = cfg_wait_states + 4'd7;
    end
    e   = sb.pop_front();
    cyc = 0;
    do begin
      @(posedge pclk); #1;
      cyc++;
    end while (!pready && cyc < 20);
    check({name, " access cycles"}, 32'(cyc), 32'(e.ws) + 32'd1);
    check({name, " pslverr"}, {31'b0, pslverr}, {31'b0, e.exp_err});
    check({name, " prdata"}, prdata, e.exp_rdata);
  endtask

  task automatic end_xfer(input string name);
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    check({name, " pready pulse"}, {31'b0, pready}, 32'd0);
  endtask

  task automatic do_xfer(input string name, input vec_t v, input bit scramble);
    setup_phase(v);
    run_access(name, scramble);
    end_xfer(name);
  endtask

  task automatic rd(input string name, input logic [31:0] addr, input logic [31:0] exp);
    vec_t v;
    v = '{1'b0, addr, 32'h0, 4'h0, 3'b000, 4'd0, 1'b0, exp};
    do_xfer(name, v, 1'b0);
  endtask

  initial begin
    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
    pwdata = '0; pstrb = '0; pprot = '0; cfg_wait_states = '0;

    vecs.push_back('{1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 3'b000, 4'd0,  1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h04, 32'h0,        4'h0, 3'b000, 4'd0,  1'b0, 32'hDEADBEEF});
    vecs.push_back('{1'b1, 32'h08, 32'hAABBCCDD, 4'hF, 3'b000, 4'd1,  1'b0, 32'h0});
    vecs.push_back('{1'b1, 32'h08, 32'h11223344, 4'h5, 3'b000, 4'd0,  1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h08, 32'h0,        4'h0, 3'b000, 4'd2,  1'b0, 32'hAA22CC44});
    vecs.push_back('{1'b0, 32'h0C, 32'h0,        4'h0, 3'b000, 4'd3,  1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h10, 32'h0,        4'h0, 3'b000, 4'd0,  1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h40, 32'h0,        4'h0, 3'b000, 4'd0,  1'b1, 32'h0});
    vecs.push_back('{1'b1, 32'h02, 32'h55555555, 4'hF, 3'b001, 4'd0,  1'b1, 32'h0});
    vecs.push_back('{1'b0, 32'h00, 32'h0,        4'h0, 3'b000, 4'd0,  1'b0, 32'h0});
    vecs.push_back('{1'b1, 32'h00, 32'hCAFEF00D, 4'hF, 3'b000, 4'd2,  1'b1, 32'h0});
    vecs.push_back('{1'b0, 32'h00, 32'h0,        4'h0, 3'b000, 4'd0,  1'b0, 32'h0});
    vecs.push_back('{1'b1, 32'h00, 32'hCAFEF00D, 4'hF, 3'b001, 4'd0,  1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h00, 32'h0,        4'h0, 3'b000, 4'd0,  1'b0, 32'hCAFEF00D});
    vecs.push_back('{1'b1, 32'h3C, 32'h12345678, 4'hF, 3'b000, 4'd1,  1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h3C, 32'h0,        4'h0, 3'b000, 4'd0,  1'b0, 32'h12345678});
    vecs.push_back('{1'b0, 32'h06, 32'h0,        4'h0, 3'b000, 4'd0,  1'b1, 32'h0});
    vecs.push_back('{1'b0, 32'hFFFFFFFC, 32'h0,  4'h0, 3'b000, 4'd1,  1'b1, 32'h0});
    vecs.push_back('{1'b0, 32'h04, 32'h0,        4'h0, 3'b000, 4'd15, 1'b0, 32'hDEADBEEF});

    repeat (2) @(posedge pclk);
    #1;
    check("reset pready", {31'b0, pready}, 32'd0);
    check("reset pslverr", {31'b0, pslverr}, 32'd0);
    check("reset prdata", prdata, 32'h0);
    preset = 1'b0;

    // penable high while idle must never start a transfer.
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h10;
    pwdata = 32'hFFFFFFFF; pstrb = 4'hF; pprot = 3'b001;
    for (int i = 0; i < 3; i++) begin
      @(posedge pclk); #1;
      check("idle penable pready", {31'b0, pready}, 32'd0);
    end
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;

    for (int i = 0; i < vecs.size(); i++)
      do_xfer($sformatf("vec%0d", i), vecs[i], 1'b0);

    // Setup abandoned: no access phase follows.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h18;
    pwdata = 32'h87654321; pstrb = 4'hF; pprot = 3'b001; cfg_wait_states = 4'd0;
    @(posedge pclk); #1;
    psel = 1'b0;
    @(posedge pclk); #1;
    check("setup abort pready", {31'b0, pready}, 32'd0);
    rd("setup abort rd", 32'h18, 32'h0);

    // psel dropped during wait states.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h14;
    pwdata = 32'h0F0F0F0F; pstrb = 4'hF; pprot = 3'b001; cfg_wait_states = 4'd3;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge pclk); #1;
      check("access abort pready", {31'b0, pready}, 32'd0);
    end
    rd("access abort rd", 32'h14, 32'h0);

    // Inputs scrambled after setup must not change the transfer.
    do_xfer("scramble wr", '{1'b1, 32'h1C, 32'h0BADF00D, 4'hF, 3'b001, 4'd2, 1'b0, 32'h0}, 1'b1);
    rd("scramble rd", 32'h1C, 32'h0BADF00D);
    rd("scramble neighbour", 32'h14, 32'h0);

    // Back-to-back write then read with no idle cycle.
    setup_phase('{1'b1, 32'h20, 32'h13579BDF, 4'hF, 3'b000, 4'd1, 1'b0, 32'h0});
    run_access("b2b wr", 1'b0);
    setup_phase('{1'b0, 32'h20, 32'h0, 4'h0, 3'b000, 4'd0, 1'b0, 32'h13579BDF});
    run_access("b2b rd", 1'b0);
    end_xfer("b2b rd");

    // Reset in the middle of a 5-wait-state write.
    setup_phase('{1'b1, 32'h24, 32'hFEEDFACE, 4'hF, 3'b000, 4'd5, 1'b0, 32'h0});
    @(posedge pclk); #1;
    penable = 1'b1;
    repeat (2) @(posedge pclk);
    #1;
    preset = 1'b1;
    @(posedge pclk); #1;
    check("mid reset pready", {31'b0, pready}, 32'd0);
    check("mid reset pslverr", {31'b0, pslverr}, 32'd0);
    preset = 1'b0; psel = 1'b0; penable = 1'b0;
    sb.delete();
    rd("mid reset target", 32'h24, 32'h0);
    rd("mid reset cleared", 32'h04, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/apb_slave_mem.md
APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

Interface
REQ-001 The block SHALL have one clock, pclk, and a synchronous, active-high reset, preset.
REQ-002 Parameter ADDRESS_WIDTH, default 32, SHALL set the paddr width.
REQ-003 Parameter DATA_WIDTH, default 32, SHALL set the pwdata/prdata width; pstrb width SHALL be DATA_WIDTH/8.
REQ-004 Parameter MEM_DEPTH, default 16, SHALL set the number of DATA_WIDTH-bit storage words.
REQ-005 Parameter BASE_ADDR, default 32'h0000_0000, SHALL set the byte address of word 0.
REQ-006 pclk  input  1  rising-edge clock.
REQ-007 preset  input  1  synchronous active-high reset.
REQ-008 psel  input  1  completer select.
REQ-009 penable  input  1  access phase indicator.
REQ-010 pwrite  input  1  1=WRITE, 0=READ.
REQ-011 paddr  input  ADDRESS_WIDTH  byte address.
REQ-012 pwdata  input  DATA_WIDTH  write data.
REQ-013 pstrb  input  DATA_WIDTH/8  write byte-lane enables.
REQ-014 pprot  input  3  protection; bit0=privileged.
REQ-015 cfg_wait_states  input  4  wait states to insert per transfer (0-15).
REQ-016 prdata  output  DATA_WIDTH  read data.
REQ-017 pready  output  1  transfer complete.
REQ-018 pslverr  output  1  1=ERROR, 0=NO_ERROR.

Function
REQ-019 The FSM SHALL have states IDLE, SETUP, ACCESS; all outputs SHALL be registered.
REQ-020 IDLE->SETUP SHALL occur at an edge with psel=1, penable=0; paddr, pwrite, pwdata, pstrb, pprot and cfg_wait_states SHALL be latched at that edge.
REQ-021 SETUP->ACCESS SHALL occur at the next edge if psel=1 and penable=1; otherwise the FSM SHALL return to IDLE with no side effect.
REQ-022 With N=latched cfg_wait_states, pready SHALL be 0 for the first N ACCESS cycles and 1 in ACCESS cycle N+1; pready SHALL be high for exactly one cycle per transfer.
REQ-023 A write SHALL update storage at the edge ending the pready=1 cycle, only byte lanes with pstrb=1, and only if pslverr=0.
REQ-024 Read data SHALL drive prdata only while pready=1 and pslverr=0; otherwise prdata SHALL be 0.
REQ-025 pslverr SHALL be 1 only with pready=1, when: address outside [BASE_ADDR, BASE_ADDR+MEM_DEPTH*DATA_WIDTH/8); or paddr not DATA_WIDTH/8-aligned; or write to word 0 with pprot[0]=0.
REQ-026 Errored reads SHALL return prdata=0; errored writes SHALL leave storage unchanged.
REQ-027 After the completing cycle, psel=1/penable=0 SHALL go directly to SETUP (back-to-back); otherwise IDLE.
REQ-028 psel deasserted during ACCESS SHALL abort to IDLE: no write, pready stays 0.
REQ-029 penable=1 while in IDLE SHALL be ignored; the FSM SHALL stay IDLE with pready=0.
REQ-030 Changes to cfg_wait_states or address/data inputs after SETUP SHALL not affect the transfer in flight.
REQ-031 Word index SHALL be (paddr-BASE_ADDR)/(DATA_WIDTH/8); out-of-range indices SHALL never access storage.

Reset
REQ-032 preset=1 SHALL force IDLE, pready=0, pslverr=0, prdata=0, and clear all storage words to 0 at the same edge.
REQ-033 Reset during SETUP or ACCESS SHALL abort the transfer with no storage update.

Verification
REQ-034 Write 0xDEADBEEF to BASE_ADDR+4, pstrb=4'hF, wait 0, then read -> pready in first ACCESS cycle, prdata=0xDEADBEEF, pslverr=0.
REQ-035 Write 0x11223344 with pstrb=4'b0101 over stored 0xAABBCCDD -> read returns 0xAA22CC44.
REQ-036 cfg_wait_states=3 read -> pready=0 for 3 ACCESS cycles, 1 in cycle 4, exactly one pulse.
REQ-037 Read BASE_ADDR+0x40 (MEM_DEPTH=16), and write BASE_ADDR+2 -> pslverr=1 with pready, prdata=0, storage unchanged.
REQ-038 Write to BASE_ADDR with pprot=3'b000 -> pslverr=1, word 0 unchanged; pprot=3'b001 -> write succeeds.
REQ-039 preset asserted during a 5-wait-state write ACCESS -> next cycle pready=0, FSM IDLE, target word reads 0.
